// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: opcodes, fixed instruction words, fetch_op codes, FSM states.
// Pure declarations, no logic or latency.
// Imported by the interface, the PC sub-block and the fetch unit.
package fetch_pkg;

  localparam int DATA_W = 10;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [3:0]        opcode_t;
  typedef logic [1:0]        fop_t;
  typedef logic [1:0]        state_t;

  localparam opcode_t OP_LI   = 4'b0001;
  localparam opcode_t OP_JMP  = 4'b1000;
  localparam opcode_t OP_BEQ  = 4'b1001;
  localparam opcode_t OP_HALT = 4'b1111;

  // Words presented downstream for a bubble and for a halt
  localparam word_t NOP_WORD  = 10'b0100000000;
  localparam word_t HALT_WORD = 10'b1111000000;

  localparam fop_t FOP_VALID  = 2'b00;
  localparam fop_t FOP_BRANCH = 2'b01;
  localparam fop_t FOP_BUBBLE = 2'b10;
  localparam fop_t FOP_HALT   = 2'b11;

  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_EXT    = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

  function automatic opcode_t opcode_of(input word_t w);
    return w[9:6];
  endfunction

  // LI, JMP and BEQ carry a second word (immediate or target)
  function automatic logic is_two_word(input opcode_t op);
    return (op == OP_LI) || (op == OP_JMP) || (op == OP_BEQ);
  endfunction

  function automatic logic is_branch(input opcode_t op);
    return (op == OP_JMP) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: downstream control in, instruction memory port, decode-facing outputs.
// Wires only, no latency.
// No backpressure of its own; stall/redirect arrive as plain level signals.
interface fetch_if #(
  parameter int ADDR_W = 10
);
  import fetch_pkg::*;

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] imem_addr;
  word_t             imem_data;
  word_t             instr;
  logic [ADDR_W-1:0] instr_addr;
  word_t             imm_val;
  word_t             jmp_addr;
  logic [2:0]        read_reg1;
  logic [2:0]        read_reg2;
  logic [ADDR_W-1:0] pc_val;
  fop_t              fetch_op;

  // Fetch unit side
  modport master (
    input  stall, redirect, redirect_addr, imem_data,
    output imem_addr, instr, instr_addr, imm_val, jmp_addr,
           read_reg1, read_reg2, pc_val, fetch_op
  );

  // Memory / pipeline side
  modport slave (
    output stall, redirect, redirect_addr, imem_data,
    input  imem_addr, instr, instr_addr, imm_val, jmp_addr,
           read_reg1, read_reg2, pc_val, fetch_op
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter register with wrap-around increment, hold and redirect load.
// PC updates one cycle after the controls; pc_inc_o is combinational from the register.
// hold_i freezes the PC; redirect_i overrides hold; rst overrides both.
module fetch_pc #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = 10'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_inc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Natural ADDR_W-bit overflow gives the modulo wrap
  assign pc_inc_o = pc_q + 1'b1;
  assign pc_o     = pc_q;

  // Next PC: redirect target, else held, else sequential
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_addr_i;
    end else if (!hold_i) begin
      pc_d = pc_inc_o;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: assembles one/two-word instructions and drives the fetch/decode register inputs.
// Outputs are combinational from state and the same-cycle imem word; two-word ops cost one bubble.
// stall freezes PC/state and emits bubbles; redirect overrides stall and restarts fetch at the target.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = 10'h000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_hold;

  state_t            state_q, state_d;
  word_t             lat_word_q, lat_word_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;

  opcode_t           cur_op;
  opcode_t           lat_op;

  word_t             instr;
  logic [ADDR_W-1:0] instr_addr;
  word_t             imm_val;
  word_t             jmp_addr;
  logic [ADDR_W-1:0] pc_val;
  fop_t              fetch_op;
  logic              regs_en;

  assign cur_op = opcode_of(bus.imem_data);
  assign lat_op = opcode_of(lat_word_q);

  // The PC stops on stall, on a HALT being fetched, and while halted
  assign pc_hold = bus.stall
                 || (state_q == ST_HALTED)
                 || ((state_q == ST_RUN) && (cur_op == OP_HALT));

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .hold_i          (pc_hold),
    .redirect_i      (bus.redirect),
    .redirect_addr_i (bus.redirect_addr),
    .pc_o            (pc),
    .pc_inc_o        (pc_inc)
  );

  // FSM and first-word latch next state; redirect drops any half-fetched instruction
  always_comb begin
    state_d    = state_q;
    lat_word_d = lat_word_q;
    lat_addr_d = lat_addr_q;
    if (bus.redirect) begin
      state_d    = ST_RUN;
      lat_word_d = '0;
      lat_addr_d = '0;
    end else if (!bus.stall) begin
      case (state_q)
        ST_RUN: begin
          if (is_two_word(cur_op)) begin
            state_d    = ST_EXT;
            lat_word_d = bus.imem_data;
            lat_addr_d = pc;
          end else if (cur_op == OP_HALT) begin
            state_d = ST_HALTED;
          end
        end
        ST_EXT:    state_d = ST_RUN;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      lat_word_q <= '0;
      lat_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_word_q <= lat_word_d;
      lat_addr_q <= lat_addr_d;
    end
  end

  // Output mux: bubble unless running unstalled and unredirected out of reset
  always_comb begin
    instr      = NOP_WORD;
    instr_addr = '0;
    imm_val    = '0;
    jmp_addr   = '0;
    pc_val     = '0;
    fetch_op   = FOP_BUBBLE;
    regs_en    = 1'b0;
    if (!rst && !bus.redirect && !bus.stall) begin
      case (state_q)
        ST_RUN: begin
          if (cur_op == OP_HALT) begin
            instr      = HALT_WORD;
            instr_addr = pc;
            fetch_op   = FOP_HALT;
          end else if (!is_two_word(cur_op)) begin
            instr      = bus.imem_data;
            instr_addr = pc;
            pc_val     = pc_inc;
            fetch_op   = FOP_VALID;
            regs_en    = 1'b1;
          end
        end
        ST_EXT: begin
          instr      = lat_word_q;
          instr_addr = lat_addr_q;
          imm_val    = (lat_op == OP_LI) ? bus.imem_data : '0;
          jmp_addr   = is_branch(lat_op) ? bus.imem_data : '0;
          pc_val     = pc_inc;
          fetch_op   = is_branch(lat_op) ? FOP_BRANCH : FOP_VALID;
          regs_en    = 1'b1;
        end
        ST_HALTED: begin
          instr      = HALT_WORD;
          instr_addr = pc;
          fetch_op   = FOP_HALT;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.instr      = instr;
  assign bus.instr_addr = instr_addr;
  assign bus.imm_val    = imm_val;
  assign bus.jmp_addr   = jmp_addr;
  assign bus.pc_val     = pc_val;
  assign bus.fetch_op   = fetch_op;
  assign bus.read_reg1  = regs_en ? instr[5:3] : 3'd0;
  assign bus.read_reg2  = regs_en ? instr[2:0] : 3'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic clk;
  logic rst;
  logic [9:0] mem [0:1023];

  int checks;
  int errors;

  fetch_if #(.ADDR_W(10)) bus ();

  fetch_unit #(
    .ADDR_W   (10),
    .RESET_PC (10'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       redir;
    logic [9:0] raddr;
    logic [9:0] e_imem;
    logic [9:0] e_instr;
    logic [9:0] e_iaddr;
    logic [9:0] e_imm;
    logic [9:0] e_jmp;
    logic [2:0] e_r1;
    logic [2:0] e_r2;
    logic [9:0] e_pc;
    logic [1:0] e_op;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [9:0] ra,
                              input logic [9:0] im, input logic [9:0] ins, input logic [9:0] ia,
                              input logic [9:0] imm, input logic [9:0] jmp,
                              input logic [2:0] r1, input logic [2:0] r2,
                              input logic [9:0] pcv, input logic [1:0] op);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.raddr = ra;
    v.e_imem = im; v.e_instr = ins; v.e_iaddr = ia; v.e_imm = imm; v.e_jmp = jmp;
    v.e_r1 = r1; v.e_r2 = r2; v.e_pc = pcv; v.e_op = op;
    return v;
  endfunction

  function automatic vec_t bub(input logic r, input logic s, input logic d, input logic [9:0] ra,
                               input logic [9:0] im);
    return mk(r, s, d, ra, im, 10'h100, 10'h000, 10'h000, 10'h000, 3'd0, 3'd0, 10'h000, 2'b10);
  endfunction

  function automatic vec_t hlt(input logic s, input logic d, input logic [9:0] ra, input logic [9:0] a);
    return mk(1'b0, s, d, ra, a, 10'h3C0, a, 10'h000, 10'h000, 3'd0, 3'd0, 10'h000, 2'b11);
  endfunction

  // Drive one cycle of inputs after the falling edge, check before the next rising edge
  task automatic apply(input string nm, input vec_t v);
    logic [72:0] act;
    logic [72:0] exp;
    @(negedge clk);
    rst               = v.rst;
    bus.stall         = v.stall;
    bus.redirect      = v.redir;
    bus.redirect_addr = v.raddr;
    #2;
    act = {bus.imem_addr, bus.instr, bus.instr_addr, bus.imm_val, bus.jmp_addr,
           bus.read_reg1, bus.read_reg2, bus.pc_val, bus.fetch_op};
    exp = {v.e_imem, v.e_instr, v.e_iaddr, v.e_imm, v.e_jmp, v.e_r1, v.e_r2, v.e_pc, v.e_op};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got imem_addr=%h instr=%h instr_addr=%h imm=%h jmp=%h rr1=%0d rr2=%0d pc_val=%h op=%b; expected imem_addr=%h instr=%h instr_addr=%h imm=%h jmp=%h rr1=%0d rr2=%0d pc_val=%h op=%b",
               nm, bus.imem_addr, bus.instr, bus.instr_addr, bus.imm_val, bus.jmp_addr,
               bus.read_reg1, bus.read_reg2, bus.pc_val, bus.fetch_op,
               v.e_imem, v.e_instr, v.e_iaddr, v.e_imm, v.e_jmp, v.e_r1, v.e_r2, v.e_pc, v.e_op);
    end
  endtask

  vec_t tbl [16];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 10'h000;
    mem[10'h000] = 10'h09D;   // 0010_011_101 one-word
    mem[10'h004] = 10'h050;   // LI 0001_010_000
    mem[10'h005] = 10'h02A;
    mem[10'h010] = 10'h3C0;   // HALT
    mem[10'h020] = 10'h0CB;   // 0011_001_011
    mem[10'h3FF] = 10'h20A;   // JMP 1000_001_010
    mem[10'h100] = 10'h0A5;   // 0010_100_101
    mem[10'h101] = 10'h271;   // BEQ 1001_110_001
    mem[10'h102] = 10'h155;
    mem[10'h104] = 10'h050;   // LI
    mem[10'h105] = 10'h033;

    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 10'h000;
    repeat (2) @(posedge clk);

    tbl[0]  = bub(1, 0, 0, 10'h000, 10'h000);
    tbl[1]  = mk(0, 0, 0, 10'h000, 10'h000, 10'h09D, 10'h000, 10'h000, 10'h000, 3'd3, 3'd5, 10'h001, 2'b00);
    tbl[2]  = mk(0, 0, 0, 10'h000, 10'h001, 10'h000, 10'h001, 10'h000, 10'h000, 3'd0, 3'd0, 10'h002, 2'b00);
    tbl[3]  = mk(0, 0, 0, 10'h000, 10'h002, 10'h000, 10'h002, 10'h000, 10'h000, 3'd0, 3'd0, 10'h003, 2'b00);
    tbl[4]  = mk(0, 0, 0, 10'h000, 10'h003, 10'h000, 10'h003, 10'h000, 10'h000, 3'd0, 3'd0, 10'h004, 2'b00);
    tbl[5]  = bub(0, 0, 0, 10'h000, 10'h004);
    tbl[6]  = mk(0, 0, 0, 10'h000, 10'h005, 10'h050, 10'h004, 10'h02A, 10'h000, 3'd2, 3'd0, 10'h006, 2'b00);
    tbl[7]  = bub(0, 1, 0, 10'h000, 10'h006);
    tbl[8]  = mk(0, 0, 0, 10'h000, 10'h006, 10'h000, 10'h006, 10'h000, 10'h000, 3'd0, 3'd0, 10'h007, 2'b00);
    tbl[9]  = bub(0, 0, 1, 10'h010, 10'h007);
    tbl[10] = hlt(0, 0, 10'h000, 10'h010);
    tbl[11] = hlt(0, 0, 10'h000, 10'h010);
    tbl[12] = bub(0, 1, 0, 10'h000, 10'h010);
    tbl[13] = hlt(0, 0, 10'h000, 10'h010);
    tbl[14] = bub(0, 1, 1, 10'h020, 10'h010);
    tbl[15] = mk(0, 0, 0, 10'h000, 10'h020, 10'h0CB, 10'h020, 10'h000, 10'h000, 3'd1, 3'd3, 10'h021, 2'b00);

    for (int i = 0; i < 16; i++) apply($sformatf("tbl[%0d]", i), tbl[i]);

    // JMP at the top of memory: second word wraps to address 0
    mem[10'h000] = 10'h100;
    apply("jmp_redir_in",  bub(0, 0, 1, 10'h3FF, 10'h021));
    apply("jmp_first",     bub(0, 0, 0, 10'h000, 10'h3FF));
    apply("jmp_ext_wrap",  mk(0, 0, 0, 10'h000, 10'h000, 10'h20A, 10'h3FF, 10'h000, 10'h100, 3'd1, 3'd2, 10'h001, 2'b01));
    apply("jmp_taken",     bub(0, 0, 1, 10'h100, 10'h001));
    apply("jmp_target",    mk(0, 0, 0, 10'h000, 10'h100, 10'h0A5, 10'h100, 10'h000, 10'h000, 3'd4, 3'd5, 10'h101, 2'b00));

    // BEQ with three stalled cycles in the second-word state
    apply("beq_first",     bub(0, 0, 0, 10'h000, 10'h101));
    for (int i = 0; i < 3; i++) apply($sformatf("beq_stall%0d", i), bub(0, 1, 0, 10'h000, 10'h102));
    apply("beq_ext",       mk(0, 0, 0, 10'h000, 10'h102, 10'h271, 10'h101, 10'h000, 10'h155, 3'd6, 3'd1, 10'h103, 2'b01));
    apply("beq_after",     mk(0, 0, 0, 10'h000, 10'h103, 10'h000, 10'h103, 10'h000, 10'h000, 3'd0, 3'd0, 10'h104, 2'b00));

    // Reset in the second-word state beats a simultaneous redirect
    mem[10'h000] = 10'h09D;
    apply("rst_li_first",  bub(0, 0, 0, 10'h000, 10'h104));
    apply("rst_in_ext",    bub(1, 0, 1, 10'h200, 10'h105));
    apply("rst_held",      bub(1, 0, 0, 10'h000, 10'h000));
    apply("rst_released",  mk(0, 0, 0, 10'h000, 10'h000, 10'h09D, 10'h000, 10'h000, 10'h000, 3'd3, 3'd5, 10'h001, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction memory address width.
REQ-002 SHALL have parameter RESET_PC, default 10'h000, PC value loaded on reset.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, synchronous, active-high.
REQ-004 SHALL have ports: stall input 1, hold fetch; redirect input 1, taken jump/branch from downstream; redirect_addr input 10, new PC.
REQ-005 SHALL have ports: imem_addr output 10, instruction memory address; imem_data input 10, asynchronous-read word at imem_addr, same cycle.
REQ-006 SHALL have outputs: instr 10, instr_addr 10, imm_val 10, jmp_addr 10, read_reg1 3, read_reg2 3, pc_val 10, fetch_op 2. These feed the fetch/decode pipeline register directly.

Function
REQ-007 SHALL decode opcode as instr[9:6]: 4'b0001 LI and 4'b1000 JMP/4'b1001 BEQ are two-word; 4'b1111 HALT; all others one-word.
REQ-008 SHALL encode fetch_op as 00 valid, 01 valid branch (BEQ/JMP, next slot squashable), 10 bubble, 11 halt.
REQ-009 SHALL implement FSM states RUN, EXT, HALTED; imem_addr = PC in all states.
REQ-010 RUN, one-word, not HALT: instr=imem_data, instr_addr=PC, pc_val=PC+1, imm_val=0, jmp_addr=0, fetch_op=00; PC<=PC+1.
REQ-011 RUN, two-word opcode: latch word and its address, output bubble (instr=10'b0100000000, other fields 0, fetch_op=10); PC<=PC+1; next EXT.
REQ-012 EXT: instr=latched word, instr_addr=latched address, imm_val=imem_data for LI else 0, jmp_addr=imem_data for JMP/BEQ else 0, pc_val=PC+1, fetch_op=01 for JMP/BEQ else 00; PC<=PC+1; next RUN.
REQ-013 read_reg1=instr[5:3], read_reg2=instr[2:0] of the presented instr; 0 on bubble/halt.
REQ-014 RUN, HALT opcode: instr=10'b1111000000, instr_addr=PC, other fields 0, fetch_op=11; PC held; next HALTED.
REQ-015 HALTED: outputs as REQ-014 every cycle; PC held; exit only by redirect or rst.
REQ-016 stall (redirect low): PC, state, latch unchanged; outputs bubble (fetch_op=10).
REQ-017 redirect: priority over stall and all states; outputs bubble this cycle; PC<=redirect_addr; next RUN; latched first word discarded.
REQ-018 PC arithmetic SHALL be modulo 2^10: 10'h3FF+1=10'h000, including second word of a two-word instruction at 10'h3FF.
REQ-019 Bubble outputs SHALL be exactly instr=10'b0100000000, all other data fields 0, fetch_op=10.

Reset
REQ-020 On rst: PC<=RESET_PC, state<=RUN, latch cleared; rst beats redirect and stall.
REQ-021 While rst high, outputs SHALL be forced to bubble values; reset mid-EXT abandons the partial instruction.

Structure
REQ-022 Shared package fetch_pkg SHALL hold opcode constants, NOP/HALT words, fetch_op codes, FSM state type.
REQ-023 One sub-module, fetch_pc, SHALL hold the PC register with increment/wrap, hold and redirect mux; FSM and output muxing stay in fetch_unit.

Verification
REQ-024 Reset, imem[0]=10'b0010_011_101 one-word -> cycle 1: instr=that word, read_reg1=3, read_reg2=5, instr_addr=0, pc_val=1, fetch_op=00.
REQ-025 imem[4]=LI (0001_010_000), imem[5]=10'h2A -> bubble, then instr=LI, imm_val=10'h2A, instr_addr=4, pc_val=6, fetch_op=00.
REQ-026 JMP at 10'h3FF, imem[0]=10'h100 -> EXT: jmp_addr=10'h100, fetch_op=01, pc_val=1; redirect=1, redirect_addr=10'h100 next -> bubble, then fetch from 10'h100.
REQ-027 stall held 3 cycles during EXT -> 3 bubbles, PC unchanged, then completed two-word instruction presented once.
REQ-028 HALT at 10'h010 -> fetch_op=11 every cycle, imem_addr stays 10'h010; redirect to 10'h020 -> bubble, then RUN from 10'h020.
REQ-029 rst asserted in EXT with simultaneous redirect -> next cycle PC=RESET_PC, RUN, bubble outputs.
